// File: rtl/frame_ctrl.sv
// frame_ctrl: classifies completed SPI frames, commits command payloads and runs
// the link watchdog / emergency-stop state machine that gates the output datapath.
module frame_ctrl #(
    parameter logic [31:0] HDR_WRITE      = 32'h74697277,
    parameter logic [31:0] HDR_READ       = 32'h64616572,
    parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [31:0]  rx_header,
    input  logic [207:0] rx_payload,
    input  logic         estop_in,
    output logic [207:0] cmd_payload,
    output logic         commit,
    output logic [31:0]  tx_header,
    output logic         fault,
    output logic [1:0]   state,
    output logic [15:0]  frame_count,
    output logic [7:0]   bad_count
);

    localparam int unsigned PAYLOAD_W = 208;
    localparam int unsigned WDOG_W    = 32;
    localparam int unsigned HDR_W     = 32;

    localparam logic [HDR_W-1:0]     TX_ESTOP    = 32'h65737470;
    localparam logic [HDR_W-1:0]     TX_DATA     = 32'h64617461;
    localparam logic [WDOG_W-1:0]    WDOG_RELOAD = WDOG_W'(TIMEOUT_CYCLES);
    // Keeps everything except joint enables [15:8] and digital outs [7:0].
    localparam logic [PAYLOAD_W-1:0] SAFE_MASK   = {{(PAYLOAD_W-16){1'b1}}, 16'h0000};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ESTOP   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 commit_q, commit_d;
    logic [HDR_W-1:0]     tx_header_q, tx_header_d;
    logic                 fault_q, fault_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic [7:0]           bad_count_q, bad_count_d;

    logic is_write;
    logic is_read;
    logic is_bad;

    // Frame classification on the completion strobe.
    always_comb begin
        is_write = rx_valid && (rx_header == HDR_WRITE);
        is_read  = rx_valid && (rx_header == HDR_READ);
        is_bad   = rx_valid && !is_write && !is_read;
    end

    // Next-state logic: e-stop beats frames, frames beat watchdog expiry.
    always_comb begin
        state_d       = state_q;
        payload_d     = payload_q;
        commit_d      = 1'b0;
        wdog_d        = wdog_q;
        frame_count_d = frame_count_q;
        bad_count_d   = bad_count_q;
        tx_header_d   = (state_q == ST_ESTOP) ? TX_ESTOP : TX_DATA;

        if (estop_in) begin
            state_d   = ST_ESTOP;
            payload_d = payload_q & SAFE_MASK;
        end else if (is_write) begin
            state_d       = ST_RUN;
            payload_d     = rx_payload;
            commit_d      = 1'b1;
            wdog_d        = WDOG_RELOAD;
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            if (is_read) begin
                wdog_d = WDOG_RELOAD;
            end else if (state_q == ST_RUN) begin
                // RUN lasts exactly TIMEOUT_CYCLES cycles after the last good frame.
                if (wdog_q <= WDOG_W'(1)) begin
                    state_d   = ST_TIMEOUT;
                    payload_d = payload_q & SAFE_MASK;
                    wdog_d    = '0;
                end else begin
                    wdog_d = wdog_q - WDOG_W'(1);
                end
            end
            if (is_bad && (bad_count_q != 8'hFF)) begin
                bad_count_d = bad_count_q + 8'd1;
            end
        end

        fault_d = (state_d == ST_TIMEOUT) || (state_d == ST_ESTOP);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            payload_q     <= '0;
            commit_q      <= 1'b0;
            tx_header_q   <= TX_DATA;
            fault_q       <= 1'b0;
            wdog_q        <= WDOG_RELOAD;
            frame_count_q <= '0;
            bad_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            payload_q     <= payload_d;
            commit_q      <= commit_d;
            tx_header_q   <= tx_header_d;
            fault_q       <= fault_d;
            wdog_q        <= wdog_d;
            frame_count_q <= frame_count_d;
            bad_count_q   <= bad_count_d;
        end
    end

    assign cmd_payload = payload_q;
    assign commit      = commit_q;
    assign tx_header   = tx_header_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign frame_count = frame_count_q;
    assign bad_count   = bad_count_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Bench for frame_ctrl: vector table, directed corner sequences and random
// traffic compared every cycle against a behavioural model of the frame rules.
module tb_frame_ctrl;

    localparam int unsigned T = 10;
    localparam logic [31:0] HW   = 32'h74697277;
    localparam logic [31:0] HR   = 32'h64616572;
    localparam logic [31:0] HBAD = 32'h0BAD0BAD;
    localparam logic [31:0] TXE  = 32'h65737470;
    localparam logic [31:0] TXD  = 32'h64617461;

    logic         clk = 1'b0;
    logic         rst, rx_valid, estop_in;
    logic [31:0]  rx_header;
    logic [207:0] rx_payload;
    logic [207:0] cmd_payload;
    logic         commit, fault;
    logic [31:0]  tx_header;
    logic [1:0]   state;
    logic [15:0]  frame_count;
    logic [7:0]   bad_count;

    always #5 clk = ~clk;

    frame_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_header(rx_header),
        .rx_payload(rx_payload), .estop_in(estop_in), .cmd_payload(cmd_payload),
        .commit(commit), .tx_header(tx_header), .fault(fault), .state(state),
        .frame_count(frame_count), .bad_count(bad_count)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: 0 idle, 1 run, 2 timeout, 3 estop; m_rem = RUN cycles left.
    logic [1:0]   m_state = 2'd0;
    logic [207:0] m_payload = '0;
    logic         m_commit = 1'b0;
    logic         m_fault = 1'b0;
    logic [31:0]  m_tx = TXD;
    logic [15:0]  m_fc = '0;
    logic [7:0]   m_bc = '0;
    int           m_rem = 0;

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] kind;
        logic       e;
        logic [7:0] pb;
        logic [1:0] x_state;
        logic       x_commit;
        logic       x_fault;
        logic [15:0] x_fc;
        logic       x_txe;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [31:0] h,
                              input logic [207:0] p, input logic e);
        if (r) begin
            m_state = 2'd0; m_payload = '0; m_commit = 1'b0; m_tx = TXD;
            m_fc = '0; m_bc = '0; m_rem = int'(T);
        end else begin
            m_commit = 1'b0;
            m_tx = (m_state == 2'd3) ? TXE : TXD;
            if (e) begin
                m_state = 2'd3;
                m_payload[15:0] = 16'h0000;
            end else if (v && h == HW) begin
                m_state = 2'd1; m_payload = p; m_commit = 1'b1;
                m_fc = m_fc + 16'd1; m_rem = int'(T);
            end else begin
                if (v && h == HR) begin
                    m_rem = int'(T);
                end else if (m_state == 2'd1) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_state = 2'd2;
                        m_payload[15:0] = 16'h0000;
                    end
                end
                if (v && h != HW && h != HR && m_bc != 8'd255) m_bc = m_bc + 8'd1;
            end
        end
        m_fault = (m_state >= 2'd2);
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] h,
                        input logic [207:0] p, input logic e);
        rst = r; rx_valid = v; rx_header = h; rx_payload = p; estop_in = e;
        @(posedge clk);
        model_edge(r, v, h, p, e);
        #1;
        chk("state",       208'(state),       208'(m_state));
        chk("commit",      208'(commit),      208'(m_commit));
        chk("fault",       208'(fault),       208'(m_fault));
        chk("cmd_payload", cmd_payload,       m_payload);
        chk("tx_header",   208'(tx_header),   208'(m_tx));
        chk("frame_count", 208'(frame_count), 208'(m_fc));
        chk("bad_count",   208'(bad_count),   208'(m_bc));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, '0, 1'b0);
    endtask

    function automatic logic [207:0] rand_pl();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[207:0];
    endfunction

    function automatic logic [31:0] hdr_of(input logic [1:0] kind);
        return (kind == 2'd0) ? HW : (kind == 2'd1) ? HR : HBAD;
    endfunction

    initial begin
        logic [207:0] pl, p2, rp;
        logic         est;
        int           run;

        rst = 1'b1; rx_valid = 1'b0; rx_header = '0; rx_payload = '0; estop_in = 1'b0;

        //            r     v     kind   e     pb      st     cm    ft    fc      txe
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'hA5, 2'd1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 16'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h3C, 2'd3, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 2'd3, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h5A, 2'd1, 1'b1, 1'b0, 16'd2, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 16'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 16'd2, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 8'h77, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h11, 2'd1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b1, 16'd0, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].v, hdr_of(tbl[i].kind), {26{tbl[i].pb}}, tbl[i].e);
            chk($sformatf("vec%0d_state", i),  208'(state),       208'(tbl[i].x_state));
            chk($sformatf("vec%0d_commit", i), 208'(commit),      208'(tbl[i].x_commit));
            chk($sformatf("vec%0d_fault", i),  208'(fault),       208'(tbl[i].x_fault));
            chk($sformatf("vec%0d_fcount", i), 208'(frame_count), 208'(tbl[i].x_fc));
            chk($sformatf("vec%0d_txhdr", i),  208'(tx_header),   208'(tbl[i].x_txe ? TXE : TXD));
            if (!tbl[i].r && tbl[i].v && !tbl[i].e && tbl[i].kind == 2'd0)
                chk($sformatf("vec%0d_payload", i), cmd_payload, {26{tbl[i].pb}});
        end

        // Watchdog expiry after exactly T RUN cycles, then bad-frame saturation.
        step(1'b1, 1'b0, 32'h0, '0, 1'b0);
        pl = rand_pl();
        pl[207:200] = 8'hC3;
        pl[15:0] = 16'hFFFF;
        step(1'b0, 1'b1, HW, pl, 1'b0);
        run = 1;
        for (int i = 0; i < 50; i++) begin
            idle();
            if (state == 2'd1) run++;
            else break;
        end
        chk("timeout_run_cycles", 208'(run), 208'(T));
        chk("timeout_state", 208'(state), 208'(2'd2));
        chk("timeout_fault", 208'(fault), 208'(1'b1));
        chk("timeout_low_cleared", 208'(cmd_payload[15:0]), 208'(16'h0000));
        chk("timeout_upper_kept", 208'(cmd_payload[207:16]), 208'(pl[207:16]));
        step(1'b0, 1'b1, HR, rand_pl(), 1'b0);
        chk("read_in_timeout_state", 208'(state), 208'(2'd2));
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, HBAD ^ 32'($urandom_range(0, 255)), rand_pl(), 1'b0);
        chk("bad_saturated", 208'(bad_count), 208'(8'd255));
        chk("bad_state_kept", 208'(state), 208'(2'd2));
        chk("bad_payload_kept", cmd_payload, {pl[207:16], 16'h0000});

        // Write landing in the cycle the watchdog expires wins and reloads.
        step(1'b0, 1'b1, HW, pl, 1'b0);
        for (int i = 0; i < int'(T) - 1; i++) idle();
        chk("pre_expiry_run", 208'(state), 208'(2'd1));
        p2 = rand_pl();
        step(1'b0, 1'b1, HW, p2, 1'b0);
        chk("race_state", 208'(state), 208'(2'd1));
        chk("race_commit", 208'(commit), 208'(1'b1));
        chk("race_payload", cmd_payload, p2);
        for (int i = 0; i < int'(T) - 1; i++) idle();
        chk("reloaded_still_run", 208'(state), 208'(2'd1));
        idle();
        chk("reloaded_then_timeout", 208'(state), 208'(2'd2));

        // frame_count wraps; reset overrides a coincident frame.
        step(1'b1, 1'b0, 32'h0, '0, 1'b0);
        for (int i = 0; i < 65537; i++) step(1'b0, 1'b1, HW, {26{8'(i)}}, 1'b0);
        chk("fcount_wrap", 208'(frame_count), 208'(16'd1));
        step(1'b1, 1'b1, HW, rand_pl(), 1'b0);
        chk("rst_commit", 208'(commit), 208'(1'b0));
        chk("rst_payload", cmd_payload, 208'(0));
        chk("rst_state", 208'(state), 208'(2'd0));
        chk("rst_fcount", 208'(frame_count), 208'(16'd0));
        chk("rst_txhdr", 208'(tx_header), 208'(TXD));

        // Random traffic against the model.
        est = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  kind;
            logic [31:0] h;
            if (est ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0)) est = ~est;
            kind = 2'($urandom_range(0, 2));
            h = (kind == 2'd2) ? $urandom : hdr_of(kind);
            rp = rand_pl();
            step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, h, rp, est);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
